dmd_frame_writer: RTL and testbench

Fills the dual-port pixel BRAM through port A from a byte stream of packed 4-bit pixels, double-buffered so the screen generator always reads a complete frame from port B. The 8192 x 4-bit BRAM holds two 128x32 frames. This block writes the back bank, then swaps banks at the next vertical sync. It sits between the host/SPI byte receiver and the BRAM write port, and drives the bank select used by the screen reader.

---
 rtl/dmd_frame_writer.sv | 138 +++++++++++++
 tb/tb_dmd_frame_writer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmd_frame_writer.sv
// Double-buffered frame writer: unpacks a byte stream of 4-bit pixel pairs into the back
// bank of the pixel BRAM (port A) and swaps banks on vertical sync once a frame is complete.
module dmd_frame_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_sof,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        vsync,
    output logic        wea,
    output logic [12:0] addra,
    output logic [3:0]  dina,
    output logic        front_bank,
    output logic        frame_done,
    output logic        resync_err
);

    // state     | meaning
    // WAIT_SOF  | idle, dropping bytes until one carries s_sof
    // LOAD      | mid-frame, ready for the next pixel pair
    // WRITE_HI  | writing the held odd pixel, input stalled
    // SWAP_WAIT | frame complete, waiting for vsync to swap banks
    typedef enum logic [1:0] {
        WAIT_SOF  = 2'd0,
        LOAD      = 2'd1,
        WRITE_HI  = 2'd2,
        SWAP_WAIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic [3:0]  hi_q, hi_d;
    logic        wea_q, wea_d;
    logic [12:0] addra_q, addra_d;
    logic [3:0]  dina_q, dina_d;
    logic        front_q, front_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic [11:0] base_idx;

    assign accept   = s_valid && ready_q;
    assign base_idx = s_sof ? 12'd0 : idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        front_d = front_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            WAIT_SOF: begin
                if (accept && s_sof) begin
                    wea_d   = 1'b1;
                    addra_d = {~front_q, 12'd0};
                    dina_d  = s_data[3:0];
                    hi_d    = s_data[7:4];
                    idx_d   = 12'd0;
                    state_d = WRITE_HI;
                end
            end
            LOAD: begin
                if (accept) begin
                    // A new SOF mid-frame abandons the partial frame and restarts at pixel 0.
                    if (s_sof) err_d = 1'b1;
                    wea_d   = 1'b1;
                    addra_d = {~front_q, base_idx};
                    dina_d  = s_data[3:0];
                    hi_d    = s_data[7:4];
                    idx_d   = base_idx;
                    state_d = WRITE_HI;
                end
            end
            WRITE_HI: begin
                wea_d   = 1'b1;
                addra_d = {~front_q, idx_q + 12'd1};
                dina_d  = hi_q;
                idx_d   = idx_q + 12'd2;
                state_d = (idx_q == 12'd4094) ? SWAP_WAIT : LOAD;
            end
            SWAP_WAIT: begin
                if (vsync) begin
                    front_d = ~front_q;
                    done_d  = 1'b1;
                    state_d = WAIT_SOF;
                end
            end
            default: state_d = WAIT_SOF;
        endcase

        // Ready is held low for the swap cycle so it returns one cycle after frame_done.
        ready_d = (state_d == LOAD) ||
                  ((state_d == WAIT_SOF) && (state_q != SWAP_WAIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_SOF;
            idx_q   <= 12'd0;
            hi_q    <= 4'd0;
            wea_q   <= 1'b0;
            addra_q <= 13'd0;
            dina_q  <= 4'd0;
            front_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            front_q <= front_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign s_ready    = ready_q;
    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign front_bank = front_q;
    assign frame_done = done_q;
    assign resync_err = err_q;

endmodule

// File: tb/tb_dmd_frame_writer.sv
// Directed bench for dmd_frame_writer: table of whole-frame patterns plus hand-written
// sequences for dropped bytes, early vsync, mid-frame resync and asynchronous reset.
module tb_dmd_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_sof = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        vsync = 1'b0;
    logic        wea;
    logic [12:0] addra;
    logic [3:0]  dina;
    logic        front_bank;
    logic        frame_done;
    logic        resync_err;

    dmd_frame_writer dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .vsync      (vsync),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .front_bank (front_bank),
        .frame_done (frame_done),
        .resync_err (resync_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        exp_front = 1'b0;
    logic        exp_resync = 1'b0;
    logic [12:0] last_addr = 13'd0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] even;
        logic [3:0] odd;
        int         resync_at;
        logic       vs_early;
        logic       front_after;
        logic       resync_after;
    } frame_t;

    frame_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge; returns at the negedge of the odd-write cycle.
    task automatic send(input logic [7:0] d, input logic sof, input logic [11:0] pix,
                        input logic [3:0] ev, input logic [3:0] od, input logic vs_early);
        int n;
        n = 0;
        s_data  = d;
        s_sof   = sof;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        vsync   = vs_early;
        @(negedge clk);
        chk("even_wea", {31'd0, wea}, 32'd1);
        chk("even_addr", {19'd0, addra}, {19'd0, ~exp_front, pix});
        chk("even_dina", {28'd0, dina}, {28'd0, ev});
        chk("busy_ready", {31'd0, s_ready}, 32'd0);
        chk("front_hold", {31'd0, front_bank}, {31'd0, exp_front});
        chk("resync_err", {31'd0, resync_err}, {31'd0, exp_resync});
        @(posedge clk);
        #1;
        vsync = 1'b0;
        @(negedge clk);
        chk("odd_wea", {31'd0, wea}, 32'd1);
        chk("odd_addr", {19'd0, addra}, {19'd0, ~exp_front, pix + 12'd1});
        chk("odd_dina", {28'd0, dina}, {28'd0, od});
        chk("no_done", {31'd0, frame_done}, 32'd0);
        last_addr = {~exp_front, pix + 12'd1};
    endtask

    task automatic drop_byte();
        chk("drop_ready_pre", {31'd0, s_ready}, 32'd1);
        s_data  = 8'h77;
        s_sof   = 1'b0;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("drop_wea", {31'd0, wea}, 32'd0);
        chk("drop_addr", {19'd0, addra}, {19'd0, last_addr});
        chk("drop_ready", {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        int total;
        int base;
        logic sof;

        tbl[0] = '{data: 8'h21, even: 4'h1, odd: 4'h2, resync_at: -1, vs_early: 1'b0,
                   front_after: 1'b1, resync_after: 1'b0};
        tbl[1] = '{data: 8'hF0, even: 4'h0, odd: 4'hF, resync_at: -1, vs_early: 1'b1,
                   front_after: 1'b0, resync_after: 1'b0};
        tbl[2] = '{data: 8'h5A, even: 4'hA, odd: 4'h5, resync_at: 100, vs_early: 1'b0,
                   front_after: 1'b1, resync_after: 1'b1};

        @(negedge clk);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_wea", {31'd0, wea}, 32'd0);
        chk("rst_addr", {19'd0, addra}, 32'd0);
        chk("rst_dina", {28'd0, dina}, 32'd0);
        chk("rst_front", {31'd0, front_bank}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_resync", {31'd0, resync_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, s_ready}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) drop_byte();
            total = (tbl[i].resync_at >= 0) ? tbl[i].resync_at + 2048 : 2048;
            for (int j = 0; j < total; j++) begin
                sof  = (j == 0) || (j == tbl[i].resync_at);
                base = (tbl[i].resync_at >= 0 && j >= tbl[i].resync_at) ? j - tbl[i].resync_at : j;
                if (j == tbl[i].resync_at) exp_resync = 1'b1;
                send(tbl[i].data, sof, 12'(base * 2), tbl[i].even, tbl[i].odd,
                     (j == total - 1) && tbl[i].vs_early);
            end
            repeat (3) begin
                @(negedge clk);
                chk("swapwait_ready", {31'd0, s_ready}, 32'd0);
                chk("swapwait_done", {31'd0, frame_done}, 32'd0);
                chk("swapwait_front", {31'd0, front_bank}, {31'd0, exp_front});
                chk("swapwait_wea", {31'd0, wea}, 32'd0);
            end
            vsync = 1'b1;
            @(posedge clk);
            #1;
            vsync = 1'b0;
            exp_front = ~exp_front;
            @(negedge clk);
            chk("swap_done", {31'd0, frame_done}, 32'd1);
            chk("swap_front", {31'd0, front_bank}, {31'd0, tbl[i].front_after});
            chk("swap_ready_low", {31'd0, s_ready}, 32'd0);
            @(negedge clk);
            chk("done_pulse_end", {31'd0, frame_done}, 32'd0);
            chk("swap_ready_high", {31'd0, s_ready}, 32'd1);
            chk("resync_sticky", {31'd0, resync_err}, {31'd0, tbl[i].resync_after});
        end

        // Reset while the odd pixel of the first byte is pending.
        s_data  = 8'h3C;
        s_sof   = 1'b1;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wea", {31'd0, wea}, 32'd0);
        chk("arst_addr", {19'd0, addra}, 32'd0);
        chk("arst_front", {31'd0, front_bank}, 32'd0);
        chk("arst_resync", {31'd0, resync_err}, 32'd0);
        chk("arst_ready", {31'd0, s_ready}, 32'd0);
        exp_front  = 1'b0;
        exp_resync = 1'b0;
        last_addr  = 13'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready_up", {31'd0, s_ready}, 32'd1);
        send(8'hC3, 1'b1, 12'd0, 4'h3, 4'hC, 1'b0);
        send(8'h12, 1'b0, 12'd2, 4'h2, 4'h1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
